// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: digit geometry, FSM states
// and the digit-range check used when operands are captured.
package bcd_pkg;

   localparam int BCD_W    = 4;
   localparam int N_DIGITS = 4;
   localparam int N_BIN    = 14;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
      return d <= BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction step for a single BCD digit:
// a digit that reached 8 or more after the right shift is pulled back by 3.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] din,
   output logic [BCD_W-1:0] dout
);

   assign dout = (din >= BCD_W'(8)) ? din - BCD_W'(3) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative four-digit BCD to binary converter (reverse double-dabble),
// one shift per clock with a start/busy/done handshake.
module bcd_to_bin #(
   parameter int N_BIN = 14,
   parameter int N_OUT = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       thousands,
   input  logic [3:0]       hundreds,
   input  logic [3:0]       tens,
   input  logic [3:0]       ones,
   output logic             busy,
   output logic             done,
   output logic [N_OUT-1:0] number,
   output logic             ovf,
   output logic             err
);

   import bcd_pkg::*;

   localparam int BCD_TOT = BCD_W * N_DIGITS;
   localparam int SR_W    = BCD_TOT + N_BIN;
   localparam int CNT_W   = $clog2(N_BIN);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [SR_W-1:0]    sr_reg, sr_next;
   logic [N_OUT-1:0]   number_reg, number_next;
   logic               ovf_reg, ovf_next;
   logic               err_reg, err_next;

   logic [SR_W-1:0]    sr_shift;
   logic [SR_W-1:0]    sr_adj;
   logic               digits_ok;

   assign sr_shift = sr_reg >> 1;
   assign sr_adj[N_BIN-1:0] = sr_shift[N_BIN-1:0];

   // Digit corrections apply to the post-shift BCD field only.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
         bcd_digit_adjust u_adj (
            .din  (sr_shift[N_BIN + gi*BCD_W +: BCD_W]),
            .dout (sr_adj  [N_BIN + gi*BCD_W +: BCD_W])
         );
      end
   endgenerate

   assign digits_ok = bcd_valid(thousands) && bcd_valid(hundreds) &&
                      bcd_valid(tens) && bcd_valid(ones);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         sr_reg     <= '0;
         number_reg <= '0;
         ovf_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         sr_reg     <= sr_next;
         number_reg <= number_next;
         ovf_reg    <= ovf_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      sr_next     = sr_reg;
      number_next = number_reg;
      ovf_next    = ovf_reg;
      err_next    = err_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               sr_next  = {thousands, hundreds, tens, ones, {N_BIN{1'b0}}};
               cnt_next = '0;
               ovf_next = 1'b0;
               err_next = 1'b0;
               if (!digits_ok) begin
                  err_next    = 1'b1;
                  number_next = '0;
                  state_next  = DONE;
               end else begin
                  state_next  = SHIFT;
               end
            end
         end
         SHIFT: begin
            sr_next  = sr_adj;
            cnt_next = cnt_reg + CNT_W'(1);
            // The final shift leaves the full binary value in the accumulator.
            if (cnt_reg == CNT_W'(N_BIN - 1)) begin
               number_next = sr_adj[N_OUT-1:0];
               ovf_next    = |sr_adj[N_BIN-1:N_OUT];
               state_next  = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy   = (state_reg == SHIFT);
   assign done   = (state_reg == DONE);
   assign number = number_reg;
   assign ovf    = ovf_reg;
   assign err    = err_reg;

endmodule
